// File: rtl/l1_mem_server_if.sv
// Mem types and the L1 cache <-> backing store request/response channel.
// A request carries one line; read responses stream back one word per beat.
package Mem;
  typedef logic [31:0]  w_t;
  typedef logic [127:0] line_t;
  typedef logic [31:0]  lineaddr_t;
endpackage

interface l1cache_mem_if;
  import Mem::*;

  logic      req_valid;
  logic      req_ready;
  logic      req_we;
  lineaddr_t req_addr;
  line_t     req_data;
  logic      resp_ack;
  w_t        resp_data;

  modport Server (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, resp_ack, resp_data
  );

  modport Client (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, resp_ack, resp_data
  );
endinterface

// File: rtl/l1_mem_server.sv
// l1_mem_server: fixed-latency line store serving L1 refills and writebacks.
// Reads stream one word per cycle; a write commits on its single ack.
module l1_mem_server
  import Mem::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  l1cache_mem_if.Server bus
);
  localparam int W  = $bits(w_t);
  localparam int WORDS_PER_LINE = $bits(line_t) / W;
  localparam int IW = $clog2(DEPTH_LINES);
  localparam int BW =
    (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [BW-1:0] LAST_BEAT =
    BW'(WORDS_PER_LINE - 1);
  // WAIT holds LATENCY-1 cycles; counts down to zero
  localparam logic [3:0] WAIT_INIT =
    4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE, WAIT, RD_BURST, WR_ACK
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            we_q, we_d;
  logic [IW-1:0]   idx_q, idx_d;
  line_t           data_q, data_d;
  line_t           mem_q [DEPTH_LINES];
  line_t           rd_line;
  logic            unused_addr;

  assign unused_addr = ^bus.req_addr[$bits(lineaddr_t)-1:IW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    we_d    = we_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          idx_d  = bus.req_addr[IW-1:0];
          data_d = bus.req_data;
          beat_d = '0;
          cnt_d  = WAIT_INIT;
          if (LATENCY > 1)
            state_d = WAIT;
          else
            state_d = bus.req_we ? WR_ACK : RD_BURST;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0)
          state_d = we_q ? WR_ACK : RD_BURST;
        else
          cnt_d = cnt_q - 4'd1;
      end
      RD_BURST: begin
        if (beat_q == LAST_BEAT)
          state_d = IDLE;
        else
          beat_d = beat_q + 1'b1;
      end
      WR_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store has no reset: contents survive rst_n
  always_ff @(posedge clk) begin
    if (state_q == WR_ACK)
      mem_q[idx_q] <= data_q;
  end

  assign rd_line = mem_q[idx_q];

  assign bus.req_ready = (state_q == IDLE);
  assign bus.resp_ack  = (state_q == RD_BURST) ||
                         (state_q == WR_ACK);
  assign bus.resp_data = (state_q == RD_BURST)
                       ? rd_line[int'(beat_q)*W +: W]
                       : '0;
endmodule

// File: tb/tb_l1_mem_server.sv
// Self-checking bench for l1_mem_server: directed cases plus random
// traffic against a line-indexed reference model.
module tb_l1_mem_server;
  import Mem::*;

  localparam int WPL = $bits(line_t) / $bits(w_t);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  line_t mdl [int];

  l1cache_mem_if b4 ();
  l1cache_mem_if b1 ();

  l1_mem_server #(.LATENCY(4), .DEPTH_LINES(256)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );
  l1_mem_server #(.LATENCY(1), .DEPTH_LINES(256)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] st(input bit s);
    if (s) return {b1.req_ready, b1.resp_ack, b1.resp_data};
    return {b4.req_ready, b4.resp_ack, b4.resp_data};
  endfunction

  function automatic line_t rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int key_of(input bit s, input lineaddr_t a);
    return int'(s) * 256 + int'(a % 256);
  endfunction

  task automatic drive(input bit s, input logic v, input logic we,
                       input lineaddr_t a, input line_t d);
    if (s) begin
      b1.req_valid = v; b1.req_we = we;
      b1.req_addr = a;  b1.req_data = d;
    end else begin
      b4.req_valid = v; b4.req_we = we;
      b4.req_addr = a;  b4.req_data = d;
    end
  endtask

  task automatic idle(input bit s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", 64'(st(s)), 64'({1'b1, 1'b0, 32'h0}));
    end
  endtask

  // Called at a negedge with the server idle; that cycle is cycle 0.
  // Returns at the negedge of the cycle where req_ready is back.
  task automatic txn(input bit s, input bit we, input lineaddr_t a,
                     input line_t d, input bit hold,
                     input lineaddr_t ha, input string tag);
    int lat, nb, key;
    line_t ln;
    logic [33:0] e;
    lat = s ? 1 : 4;
    nb  = we ? 1 : WPL;
    key = key_of(s, a);
    ln  = mdl.exists(key) ? mdl[key] : '0;
    drive(s, 1'b1, we, a, d);
    chk({tag, "_c0"}, 64'(st(s)), 64'({1'b1, 1'b0, 32'h0}));
    for (int c = 1; c <= lat + nb; c++) begin
      @(negedge clk);
      e = '0;
      e[33] = (c == lat + nb);
      if (c >= lat && c < lat + nb) begin
        e[32] = 1'b1;
        if (!we) e[31:0] = ln[(c - lat) * 32 +: 32];
      end
      chk($sformatf("%s_c%0d", tag, c), 64'(st(s)), 64'(e));
      if (c == 1) drive(s, hold, 1'b0, ha, rnd_line());
    end
    if (we) mdl[key] = d;
  endtask

  initial begin
    line_t l1, l55, laa;
    lineaddr_t a;
    bit we;
    l1  = {32'h44, 32'h33, 32'h22, 32'h11};
    l55 = {4{32'h55}};
    laa = {4{32'hAA}};
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst4", 64'(st(0)), 64'({1'b1, 1'b0, 32'h0}));
    chk("rst1", 64'(st(1)), 64'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted on first edge after reset release
    txn(0, 1'b1, 32'h10, l1, 1'b0, '0, "wr10");
    txn(0, 1'b0, 32'h10, '0, 1'b0, '0, "rd10");
    txn(0, 1'b1, 32'h30, rnd_line(), 1'b0, '0, "wr30");
    txn(0, 1'b1, 32'h20, l55, 1'b0, '0, "wr20");

    // Different request held during a read burst
    txn(0, 1'b0, 32'h10, '0, 1'b1, 32'h30, "hold");
    txn(0, 1'b0, 32'h30, '0, 1'b0, '0, "rd30");

    // Write aborted by reset in cycle 2
    drive(0, 1'b1, 1'b1, 32'h20, laa);
    chk("ab_c0", 64'(st(0)), 64'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    chk("ab_c1", 64'(st(0)), 64'(0));
    @(negedge clk);
    chk("ab_c2", 64'(st(0)), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("ab_rst", 64'(st(0)), 64'({1'b1, 1'b0, 32'h0}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_hold", 64'(st(0)), 64'({1'b1, 1'b0, 32'h0}));
    end
    rst_n = 1'b1;
    idle(0, 4);
    txn(0, 1'b0, 32'h20, '0, 1'b0, '0, "rd20");
    txn(0, 1'b0, 32'h10, '0, 1'b0, '0, "rd10b");

    // Aliasing: 0x105 and 0x005 share a line
    txn(0, 1'b1, 32'h105, rnd_line(), 1'b0, '0, "wr105");
    txn(0, 1'b0, 32'h005, '0, 1'b0, '0, "rd005");

    // LATENCY=1 build
    idle(1, 1);
    txn(1, 1'b1, 32'h7, rnd_line(), 1'b0, '0, "l1wr");
    txn(1, 1'b0, 32'h7, '0, 1'b0, '0, "l1rd");
    txn(1, 1'b0, 32'h7, '0, 1'b0, '0, "l1rd2");

    // Random traffic on a small aliased window
    for (int n = 0; n < 30; n++) begin
      a  = ($urandom & 32'hFFFF_FF00) |
           (32'h40 + 32'($urandom_range(0, 7)));
      we = 1'($urandom_range(0, 1));
      if (!mdl.exists(key_of(0, a))) we = 1'b1;
      txn(0, we, a, rnd_line(), 1'b0, '0,
          $sformatf("rnd%0d", n));
      idle(0, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
